mem_access_ctrl: RTL and testbench

//   Request/response front end for the 256x16 data RAM. Accepts one load or store
//   per transaction from the datapath over a valid/ready handshake, drives the
//   RAM port (w_en/addr/d_in), absorbs the RAM's fixed read latency and returns
//   the result on a response channel that supports backpressure.

---
 rtl/mem_access_ctrl_if.sv | 26 ++
 rtl/mem_access_ctrl.sv | 109 ++++++++++
 tb/tb_mem_access_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Request/response channels between the datapath (master) and the memory
// access controller (slave).
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_is_wr;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_is_wr
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_is_wr
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store front end for a synchronous RAM with a fixed
// read latency; responses are held until the consumer accepts them.
module mem_access_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_access_ctrl_if.slave  bus,
    output logic              busy,
    output logic              ram_w_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_d_in,
    input  logic [DATA_W-1:0] ram_d_out
);

    generate
        if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
            $error("mem_access_ctrl: RD_LAT must be in 1..4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state_reg;
    logic [1:0]        wait_cnt_reg;
    logic              req_ready_reg;
    logic              rsp_valid_reg;
    logic [DATA_W-1:0] rsp_rdata_reg;
    logic              rsp_is_wr_reg;
    logic              ram_w_en_reg;
    logic [ADDR_W-1:0] ram_addr_reg;
    logic [DATA_W-1:0] ram_d_in_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= '0;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_is_wr_reg <= 1'b0;
            ram_w_en_reg  <= 1'b0;
            ram_addr_reg  <= '0;
            ram_d_in_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // req_ready comes up on the first edge out of reset
                    if (!req_ready_reg) begin
                        req_ready_reg <= 1'b1;
                    end else if (bus.req_valid) begin
                        ram_addr_reg  <= bus.req_addr;
                        ram_d_in_reg  <= bus.req_wdata;
                        ram_w_en_reg  <= bus.req_we;
                        rsp_is_wr_reg <= bus.req_we;
                        req_ready_reg <= 1'b0;
                        state_reg     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (rsp_is_wr_reg) begin
                        ram_w_en_reg  <= 1'b0;
                        rsp_rdata_reg <= ram_d_in_reg;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end else begin
                        wait_cnt_reg <= 2'(RD_LAT - 1);
                        state_reg    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt_reg != 2'd0) begin
                        wait_cnt_reg <= wait_cnt_reg - 2'd1;
                    end else begin
                        rsp_rdata_reg <= ram_d_out;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end
                end
                RESP: begin
                    // no accept on the handshake edge; IDLE sees req_ready next cycle
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign bus.rsp_is_wr = rsp_is_wr_reg;
    assign ram_w_en      = ram_w_en_reg;
    assign ram_addr      = ram_addr_reg;
    assign ram_d_in      = ram_d_in_reg;
    assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: RD_LAT=1 instance with scoreboard plus an RD_LAT=3
// instance for the latency check; both drive behavioural RAMs.
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_ctrl_if #(.ADDR_W(8), .DATA_W(16)) bus1 ();
    mem_access_ctrl_if #(.ADDR_W(8), .DATA_W(16)) bus3 ();

    logic        busy1, busy3;
    logic        ram1_w_en, ram3_w_en;
    logic [7:0]  ram1_addr, ram3_addr;
    logic [15:0] ram1_d_in, ram3_d_in, ram1_d_out, ram3_d_out;

    mem_access_ctrl #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .busy(busy1),
        .ram_w_en(ram1_w_en), .ram_addr(ram1_addr), .ram_d_in(ram1_d_in),
        .ram_d_out(ram1_d_out)
    );

    mem_access_ctrl #(.ADDR_W(8), .DATA_W(16), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3), .busy(busy3),
        .ram_w_en(ram3_w_en), .ram_addr(ram3_addr), .ram_d_in(ram3_d_in),
        .ram_d_out(ram3_d_out)
    );

    // behavioural RAMs: contents are not affected by reset
    logic [15:0] mem1 [256];
    logic [15:0] mem3 [256];
    logic [15:0] pipe1;
    logic [15:0] pipe3 [3];
    logic [15:0] shadow [256];

    always @(posedge clk) begin
        if (ram1_w_en) mem1[ram1_addr] <= ram1_d_in;
        pipe1 <= mem1[ram1_addr];
        if (ram3_w_en) mem3[ram3_addr] <= ram3_d_in;
        pipe3[0] <= mem3[ram3_addr];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign ram1_d_out = pipe1;
    assign ram3_d_out = pipe3[2];

    typedef struct {
        logic        is_wr;
        logic [15:0] rdata;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        bit          we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        int          exp_lat;
    } vec_t;
    vec_t vecs[8];

    int n_checks = 0;
    int n_fail   = 0;
    int resp_cnt = 0;
    int wen_cnt  = 0;
    bit rand_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // scoreboard consumer: one pop per response handshake
    always @(negedge clk) begin
        exp_t e;
        if (ram1_w_en) wen_cnt++;
        if (rst_n && bus1.rsp_valid && bus1.rsp_ready) begin
            resp_cnt++;
            if (sb_q.size() == 0) begin
                chk("rsp_unexpected", 32'(bus1.rsp_valid), 32'd0);
            end else begin
                e = sb_q.pop_front();
                $display("rsp %0d: is_wr=%0d rdata=%h (exp %0d/%h)", resp_cnt,
                         bus1.rsp_is_wr, bus1.rsp_rdata, e.is_wr, e.rdata);
                chk("rsp_rdata", 32'(bus1.rsp_rdata), 32'(e.rdata));
                chk("rsp_is_wr", 32'(bus1.rsp_is_wr), 32'(e.is_wr));
            end
        end
    end

    always @(posedge clk) begin
        if (rand_mode) begin
            #1;
            bus1.rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},      32'(busy1),          32'd0);
        chk({tag, "_req_ready"}, 32'(bus1.req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(bus1.rsp_valid), 32'd0);
        chk({tag, "_rsp_rdata"}, 32'(bus1.rsp_rdata), 32'd0);
        chk({tag, "_rsp_is_wr"}, 32'(bus1.rsp_is_wr), 32'd0);
        chk({tag, "_ram_w_en"},  32'(ram1_w_en),      32'd0);
        chk({tag, "_ram_addr"},  32'(ram1_addr),      32'd0);
        chk({tag, "_ram_d_in"},  32'(ram1_d_in),      32'd0);
    endtask

    // call just after a rising edge; returns just after the accepting edge
    task automatic accept_only(input bit we, input logic [7:0] a, input logic [15:0] d);
        bit ok = 0;
        bus1.req_valid = 1'b1;
        bus1.req_we    = we;
        bus1.req_addr  = a;
        bus1.req_wdata = d;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus1.req_ready) begin
                @(posedge clk);
                ok = 1;
                break;
            end
        end
        #1;
        bus1.req_valid = 1'b0;
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input bit we, input logic [7:0] a, input logic [15:0] d,
                        input logic [15:0] exp_rdata);
        exp_t e;
        e.is_wr = we;
        e.rdata = exp_rdata;
        sb_q.push_back(e);
        if (we) shadow[a] = d;
        accept_only(we, a, d);
    endtask

    task automatic wait_valid(input string name, input int exp_lat);
        int n = 0;
        while (n < 20) begin
            @(posedge clk);
            n++;
            #1;
            if (bus1.rsp_valid) break;
        end
        chk(name, 32'(n), 32'(exp_lat));
    endtask

    task automatic wait_sb_empty();
        int k = 0;
        while (sb_q.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic run_txn(input vec_t v);
        bus1.rsp_ready = 1'b1;
        wen_cnt = 0;
        send(v.we, v.addr, v.wdata, v.exp_rdata);
        wait_valid("latency", v.exp_lat);
        @(posedge clk);
        #1;
        chk("req_ready_after_rsp", 32'(bus1.req_ready), 32'd1);
        chk("rsp_valid_after_rsp", 32'(bus1.rsp_valid), 32'd0);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("w_en_pulses", 32'(wen_cnt), v.we ? 32'd1 : 32'd0);
        chk("ram_addr_hold", 32'(ram1_addr), 32'(v.addr));
    endtask

    initial begin
        int n;
        int rand_base;
        bit ok;
        logic [7:0] ra;
        logic [15:0] rd;
        bit rw;

        for (int i = 0; i < 256; i++) begin
            mem1[i]   = 16'(i) ^ 16'hA5A5;
            mem3[i]   = 16'(i) ^ 16'hA5A5;
            shadow[i] = 16'(i) ^ 16'hA5A5;
        end
        vecs[0] = '{1'b1, 8'h12, 16'hBEEF, 16'hBEEF, 1};
        vecs[1] = '{1'b0, 8'h12, 16'h0000, 16'hBEEF, 2};
        vecs[2] = '{1'b0, 8'h12, 16'h0000, 16'hBEEF, 2};
        vecs[3] = '{1'b1, 8'hFF, 16'h0001, 16'h0001, 1};
        vecs[4] = '{1'b1, 8'h00, 16'h0002, 16'h0002, 1};
        vecs[5] = '{1'b0, 8'hFF, 16'h0000, 16'h0001, 2};
        vecs[6] = '{1'b0, 8'h00, 16'h0000, 16'h0002, 2};
        vecs[7] = '{1'b0, 8'h13, 16'h0000, 16'hA5B6, 2};

        bus1.req_valid = 0; bus1.req_we = 0; bus1.req_addr = 0; bus1.req_wdata = 0;
        bus1.rsp_ready = 0;
        bus3.req_valid = 0; bus3.req_we = 0; bus3.req_addr = 0; bus3.req_wdata = 0;
        bus3.rsp_ready = 0;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("req_ready_before_edge", 32'(bus1.req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("req_ready_first_edge", 32'(bus1.req_ready), 32'd1);
        chk("req_ready_first_edge3", 32'(bus3.req_ready), 32'd1);

        for (int i = 0; i < 2; i++) run_txn(vecs[i]);

        // backpressure on a load; a req_valid pulse during RESP must be ignored
        bus1.rsp_ready = 1'b0;
        send(1'b0, 8'h12, 16'h0000, 16'hBEEF);
        wait_valid("bp_latency", 2);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("bp_rsp_valid", 32'(bus1.rsp_valid), 32'd1);
            chk("bp_rsp_rdata", 32'(bus1.rsp_rdata), 32'hBEEF);
            chk("bp_req_ready", 32'(bus1.req_ready), 32'd0);
            if (c == 1) begin
                bus1.req_valid = 1'b1; bus1.req_we = 1'b1;
                bus1.req_addr = 8'h12; bus1.req_wdata = 16'h1111;
            end
            if (c == 2) bus1.req_valid = 1'b0;
        end
        bus1.rsp_ready = 1'b1;
        wait_sb_empty();
        @(posedge clk);
        #1;
        chk("bp_req_ready_after", 32'(bus1.req_ready), 32'd1);

        for (int i = 2; i < 8; i++) run_txn(vecs[i]);

        // RD_LAT=3 instance: load of untouched address 0x12
        bus3.rsp_ready = 1'b1;
        bus3.req_valid = 1'b1; bus3.req_we = 1'b0; bus3.req_addr = 8'h12;
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus3.req_ready) begin
                @(posedge clk);
                ok = 1;
                break;
            end
        end
        #1;
        bus3.req_valid = 1'b0;
        chk("lat3_accept", 32'(ok), 32'd1);
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            n++;
            #1;
            if (bus3.rsp_valid) break;
        end
        chk("lat3_latency", 32'(n), 32'd4);
        chk("lat3_rdata", 32'(bus3.rsp_rdata), 32'hA5B7);
        chk("lat3_is_wr", 32'(bus3.rsp_is_wr), 32'd0);
        @(posedge clk);
        #1;
        chk("lat3_req_ready", 32'(bus3.req_ready), 32'd1);

        // reset during ACCESS of a store: nothing committed, outputs reset at once
        accept_only(1'b1, 8'h40, 16'hDEAD);
        chk("rst_w_en_before", 32'(ram1_w_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_txn('{1'b0, 8'h40, 16'h0000, 16'hA5E5, 2});

        // random mix against the shadow model
        rand_base = resp_cnt;
        rand_mode = 1;
        for (int t = 0; t < 1000; t++) begin
            rw = 1'($urandom_range(0, 1));
            ra = 8'($urandom_range(0, 15)) + 8'hF8;
            rd = 16'($urandom);
            send(rw, ra, rd, rw ? rd : shadow[ra]);
            wait_sb_empty();
        end
        rand_mode = 0;
        @(posedge clk);
        #1;
        bus1.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rand_rsp_count", 32'(resp_cnt - rand_base), 32'd1000);
        chk("rand_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
